// File: rtl/logic_pod_lane_arbiter.sv
// Merges the compressed streams of one logic pod: a FIFO per lane, then a round-robin
// pick into a single registered output word with a valid/ready handshake.
module logic_pod_lane_arbiter #(
    parameter int LANES = 8,
    parameter int DEPTH = 16,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES-1:0]    in_valid,
    input  logic [LANES-1:0]    in_format,
    input  logic [16*LANES-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LW-1:0]       out_lane,
    output logic                out_format,
    output logic [15:0]         out_data,
    output logic [LANES-1:0]    overflow,
    input  logic                overflow_clear
);

    logic [16:0]      mem_r      [LANES][DEPTH];
    logic [AW-1:0]    wr_ptr_r   [LANES];
    logic [AW-1:0]    rd_ptr_r   [LANES];
    logic [CW-1:0]    count_r    [LANES];
    logic [LW-1:0]    last_grant_r;
    logic             out_valid_r;
    logic [LW-1:0]    out_lane_r;
    logic             out_format_r;
    logic [15:0]      out_data_r;
    logic [LANES-1:0] overflow_r;

    logic             load_s;
    logic             grant_found_s;
    logic [LW-1:0]    grant_idx_s;
    logic [16:0]      grant_word_s;
    logic [LANES-1:0] pop_s;
    logic [LANES-1:0] accept_s;
    logic [LANES-1:0] drop_s;

    // Round-robin search: walk backwards so the first candidate after last_grant wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = LANES; k >= 1; k--) begin
            int  sum_v;
            int  cand_v;
            logic hit_v;
            sum_v         = int'(last_grant_r) + k;
            cand_v        = (sum_v >= LANES) ? (sum_v - LANES) : sum_v;
            hit_v         = (count_r[cand_v] != '0);
            grant_idx_s   = hit_v ? LW'(cand_v) : grant_idx_s;
            grant_found_s = grant_found_s | hit_v;
        end
    end

    // Load/pop/accept decisions for the current edge.
    always_comb begin
        load_s       = !out_valid_r || out_ready;
        grant_word_s = mem_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
        pop_s        = '0;
        accept_s     = '0;
        drop_s       = '0;
        for (int i = 0; i < LANES; i++) begin
            pop_s[i]    = load_s && grant_found_s && (grant_idx_s == LW'(i));
            // A full lane still takes a word when it is being drained on the same edge.
            accept_s[i] = in_valid[i] && ((count_r[i] != CW'(DEPTH)) || pop_s[i]);
            drop_s[i]   = in_valid[i] && !accept_s[i];
        end
    end

    // Per-lane FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                wr_ptr_r[i] <= wr_ptr_r[i] + AW'(accept_s[i]);
                rd_ptr_r[i] <= rd_ptr_r[i] + AW'(pop_s[i]);
                count_r[i]  <= count_r[i] + CW'(accept_s[i]) - CW'(pop_s[i]);
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!rst && accept_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= {in_format[i], in_data[16*i +: 16]};
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_lane_r   <= '0;
            out_format_r <= 1'b0;
            out_data_r   <= 16'h0000;
            last_grant_r <= LW'(LANES - 1);
        end else if (load_s) begin
            if (grant_found_s) begin
                out_valid_r  <= 1'b1;
                out_lane_r   <= grant_idx_s;
                out_format_r <= grant_word_s[16];
                out_data_r   <= grant_word_s[15:0];
                last_grant_r <= grant_idx_s;
            end else begin
                out_valid_r  <= 1'b0;
            end
        end
    end

    // Sticky drop flags; a drop on the clearing edge still leaves its bit set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= '0;
        end else if (overflow_clear) begin
            overflow_r <= drop_s;
        end else begin
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_lane   = out_lane_r;
    assign out_format = out_format_r;
    assign out_data   = out_data_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_logic_pod_lane_arbiter.sv
// Directed bench for logic_pod_lane_arbiter: one task per scenario with inline checks.
`timescale 1ns/1ps
module tb_logic_pod_lane_arbiter;

    logic         clk;
    logic         rst;
    logic [7:0]   in_valid;
    logic [7:0]   in_format;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_lane;
    logic         out_format;
    logic [15:0]  out_data;
    logic [7:0]   overflow;
    logic         overflow_clear;

    int n_cmp = 0;
    int n_err = 0;

    logic_pod_lane_arbiter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_format(in_format), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
        .out_format(out_format), .out_data(out_data), .overflow(overflow),
        .overflow_clear(overflow_clear)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid  = 8'h00;
        in_format = 8'h00;
        in_data   = 128'h0;
    endtask

    task automatic push(input int lane, input logic fmt, input logic [15:0] data);
        in_valid[lane]           = 1'b1;
        in_format[lane]          = fmt;
        in_data[16*lane +: 16]   = data;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        out_ready      = 1'b1;
        overflow_clear = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_lane !== 3'd0) begin n_err++; $display("FAIL reset_lane got %0d want 0", out_lane); end
        n_cmp++; if (out_format !== 1'b0) begin n_err++; $display("FAIL reset_format got %0b want 0", out_format); end
        n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_data got %h want 0000", out_data); end
        n_cmp++; if (overflow !== 8'h00) begin n_err++; $display("FAIL reset_overflow got %h want 00", overflow); end
    endtask

    task automatic test_single();
        apply_reset();
        push(2, 1'b1, 16'hBEEF);
        step();
        clear_inputs();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early got %0b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b want 1", out_valid); end
        n_cmp++; if (out_lane !== 3'd2) begin n_err++; $display("FAIL single_lane got %0d want 2", out_lane); end
        n_cmp++; if (out_data !== 16'hBEEF) begin n_err++; $display("FAIL single_data got %h want BEEF", out_data); end
        n_cmp++; if (out_format !== 1'b1) begin n_err++; $display("FAIL single_format got %0b want 1", out_format); end
        n_cmp++; if (overflow !== 8'h00) begin n_err++; $display("FAIL single_overflow got %h want 00", overflow); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_after got %0b want 0", out_valid); end
    endtask

    task automatic test_burst();
        apply_reset();
        for (int i = 0; i < 8; i++) push(i, i[0], 16'h1000 + 16'(i));
        step();
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL burst_valid[%0d] got %0b want 1", i, out_valid); end
            n_cmp++; if (out_lane !== 3'(i)) begin n_err++; $display("FAIL burst_lane[%0d] got %0d want %0d", i, out_lane, i); end
            n_cmp++; if (out_data !== 16'h1000 + 16'(i)) begin n_err++; $display("FAIL burst_data[%0d] got %h want %h", i, out_data, 16'h1000 + 16'(i)); end
            n_cmp++; if (out_format !== (i % 2 == 1)) begin n_err++; $display("FAIL burst_format[%0d] got %0b want %0b", i, out_format, i % 2); end
        end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL burst_end got %0b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            if (c < 3) push(5, 1'b0, 16'h00A0 + 16'(c));
            step();
            if (c >= 1) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %0b want 1", c, out_valid); end
                n_cmp++; if (out_data !== 16'h00A0) begin n_err++; $display("FAIL stall_data[%0d] got %h want 00A0", c, out_data); end
                n_cmp++; if (out_lane !== 3'd5) begin n_err++; $display("FAIL stall_lane[%0d] got %0d want 5", c, out_lane); end
            end
        end
        clear_inputs();
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h00A0 + 16'(j)) begin
                n_err++; $display("FAIL drain_word[%0d] got v=%0b %h want v=1 %h", j, out_valid, out_data, 16'h00A0 + 16'(j));
            end
            step();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_end got %0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            clear_inputs();
            push(3, 1'b0, 16'(k));
            step();
            n_cmp++; if (overflow !== ((k >= 17) ? 8'h08 : 8'h00)) begin
                n_err++; $display("FAIL ovf_flag[%0d] got %h want %h", k, overflow, (k >= 17) ? 8'h08 : 8'h00);
            end
        end
        clear_inputs();
        out_ready = 1'b1;
        for (int j = 0; j < 17; j++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'(j)) begin
                n_err++; $display("FAIL ovf_word[%0d] got v=%0b %h want v=1 %h", j, out_valid, out_data, 16'(j));
            end
            step();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_count got extra word %h", out_data); end
        n_cmp++; if (overflow !== 8'h08) begin n_err++; $display("FAIL ovf_sticky got %h want 08", overflow); end
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        n_cmp++; if (overflow !== 8'h00) begin n_err++; $display("FAIL ovf_clear got %h want 00", overflow); end
    endtask

    task automatic test_fairness();
        apply_reset();
        for (int s = 0; s < 40; s++) begin
            clear_inputs();
            push(0, 1'b0, 16'(s));
            push(5, 1'b1, 16'(s));
            step();
            if (s >= 1) begin
                n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fair_idle[%0d] got %0b want 1", s, out_valid); end
                n_cmp++; if (out_lane !== ((s % 2 == 1) ? 3'd0 : 3'd5)) begin
                    n_err++; $display("FAIL fair_lane[%0d] got %0d want %0d", s, out_lane, (s % 2 == 1) ? 0 : 5);
                end
            end
        end
        clear_inputs();
        n_cmp++; if (overflow[5] !== 1'b1) begin n_err++; $display("FAIL fair_ovf5 got %0b want 1", overflow[5]); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            push(1, 1'b0, 16'h0100 + 16'(c));
            push(2, 1'b0, 16'h0200 + 16'(c));
            push(4, 1'b1, 16'h0400 + 16'(c));
            push(6, 1'b1, 16'h0600 + 16'(c));
            step();
        end
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %0b want 0", out_valid); end
        n_cmp++; if (overflow !== 8'h00) begin n_err++; $display("FAIL mid_overflow got %h want 00", overflow); end
        out_ready = 1'b1;
        push(7, 1'b1, 16'h7777);
        step();
        clear_inputs();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_early got %0b want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_lane !== 3'd7 || out_data !== 16'h7777) begin
            n_err++; $display("FAIL mid_word got v=%0b lane=%0d %h want v=1 lane=7 7777", out_valid, out_lane, out_data);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale[%0d] got lane=%0d %h", c, out_lane, out_data); end
        end
    endtask

    initial begin
        rst            = 1'b1;
        out_ready      = 1'b1;
        overflow_clear = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_overflow();
        test_fairness();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
